// File: rtl/matrix_stream_emitter.sv
// Buffers matrix elements in a FIFO and streams them out row by row, with a
// row-end pulse after each row and a matrix-end pulse after the last row.
module matrix_stream_emitter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIM_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          cfg_valid,
  input  logic [DIM_WIDTH-1:0]          cfg_rows,
  input  logic [DIM_WIDTH-1:0]          cfg_cols,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          in_ready,
  output logic                          out_matrix_en,
  output logic [DATA_WIDTH-1:0]         out_matrix,
  output logic                          out_matrix_end_row,
  output logic                          out_matrix_end,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LevelFull = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    ROW_END,
    MAT_END
  } state_t;

  state_t                state_q, state_d;
  logic [DIM_WIDTH-1:0]  rows_q, rows_d, cols_q, cols_d;
  logic [DIM_WIDTH-1:0]  row_q, row_d, col_q, col_d;
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic                  push, pop;
  logic                  en_d, end_row_d, end_d;
  logic [DATA_WIDTH-1:0] data_d;

  // Readiness depends only on the registered level, so a full FIFO refuses
  // a push even when the same cycle pops.
  assign in_ready = resetn && (level != LevelFull);
  assign push     = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    row_d     = row_q;
    col_d     = col_q;
    pop       = 1'b0;
    en_d      = 1'b0;
    end_row_d = 1'b0;
    end_d     = 1'b0;
    data_d    = out_matrix;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid && (cfg_rows != '0) && (cfg_cols != '0)) begin
          rows_d  = cfg_rows;
          cols_d  = cfg_cols;
          row_d   = '0;
          col_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (level != '0) begin
          pop    = 1'b1;
          en_d   = 1'b1;
          data_d = mem_q[rd_ptr_q];
          if (col_q == cols_q - DIM_WIDTH'(1)) begin
            col_d   = '0;
            state_d = ROW_END;
          end else begin
            col_d = col_q + DIM_WIDTH'(1);
          end
        end
      end
      ROW_END: begin
        end_row_d = 1'b1;
        if (row_q == rows_q - DIM_WIDTH'(1)) begin
          state_d = MAT_END;
        end else begin
          row_d   = row_q + DIM_WIDTH'(1);
          state_d = EMIT;
        end
      end
      MAT_END: begin
        end_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q            <= IDLE;
      busy               <= 1'b0;
      rows_q             <= '0;
      cols_q             <= '0;
      row_q              <= '0;
      col_q              <= '0;
      out_matrix_en      <= 1'b0;
      out_matrix         <= '0;
      out_matrix_end_row <= 1'b0;
      out_matrix_end     <= 1'b0;
    end else begin
      state_q            <= state_d;
      busy               <= (state_d != IDLE);
      rows_q             <= rows_d;
      cols_q             <= cols_d;
      row_q              <= row_d;
      col_q              <= col_d;
      out_matrix_en      <= en_d;
      out_matrix         <= data_d;
      out_matrix_end_row <= end_row_d;
      out_matrix_end     <= end_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_matrix_stream_emitter.sv
// Directed self-checking bench for matrix_stream_emitter (8-bit data, depth 16).
module tb_matrix_stream_emitter;

  logic       clk;
  logic       resetn;
  logic       cfg_valid;
  logic [7:0] cfg_rows;
  logic [7:0] cfg_cols;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_matrix_en;
  logic [7:0] out_matrix;
  logic       out_matrix_end_row;
  logic       out_matrix_end;
  logic       busy;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;

  matrix_stream_emitter #(
    .DATA_WIDTH(8),
    .DIM_WIDTH (8),
    .FIFO_DEPTH(16)
  ) dut (
    .clk               (clk),
    .resetn            (resetn),
    .cfg_valid         (cfg_valid),
    .cfg_rows          (cfg_rows),
    .cfg_cols          (cfg_cols),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .out_matrix_en     (out_matrix_en),
    .out_matrix        (out_matrix),
    .out_matrix_end_row(out_matrix_end_row),
    .out_matrix_end    (out_matrix_end),
    .busy              (busy),
    .level             (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {out_matrix_en, out_matrix_end_row, out_matrix_end, out_matrix};
  endfunction

  initial begin
    int         n_en;
    int         n_row;
    int         n_end;
    logic [7:0] last;
    logic [10:0] seq_2x3 [9];

    seq_2x3 = '{{3'b100, 8'd1}, {3'b100, 8'd2}, {3'b100, 8'd3}, {3'b010, 8'd3},
                {3'b100, 8'd4}, {3'b100, 8'd5}, {3'b100, 8'd6}, {3'b010, 8'd6},
                {3'b001, 8'd6}};

    resetn    = 1'b0;
    cfg_valid = 1'b0;
    cfg_rows  = '0;
    cfg_cols  = '0;
    in_valid  = 1'b0;
    in_data   = '0;

    // Reset held for 5 cycles
    for (int i = 0; i < 5; i++) tick();
    check("rst_outs", 32'(outs()), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    resetn = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);
    check("rel_level", 32'(level), 32'd0);
    check("rel_busy", 32'(busy), 32'd0);

    // 2x3 pre-loaded
    for (int i = 1; i <= 6; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    check("pre_level", 32'(level), 32'd6);
    check("pre_busy_idle", 32'(busy), 32'd0);
    cfg_valid = 1'b1;
    cfg_rows  = 8'd2;
    cfg_cols  = 8'd3;
    tick();
    cfg_valid = 1'b0;
    check("cfg_busy", 32'(busy), 32'd1);
    check("cfg_no_out", 32'(outs()), 32'(11'h0) | 32'(out_matrix));
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("seq2x3_%0d", i), 32'(outs()), 32'(seq_2x3[i]));
    end
    check("seq2x3_busy", 32'(busy), 32'd0);
    check("seq2x3_level", 32'(level), 32'd0);

    // Full FIFO: 16 accepted, 17th held off until a pop
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(100 + i);
      tick();
    end
    in_data = 8'd200;
    check("full_level", 32'(level), 32'd16);
    check("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("full_refused", 32'(level), 32'd16);
    cfg_valid = 1'b1;
    cfg_rows  = 8'd1;
    cfg_cols  = 8'd1;
    tick();
    cfg_valid = 1'b0;
    check("full_no_push_on_cfg", 32'(level), 32'd16);
    tick();
    check("full_pop_out", 32'(outs()), 32'({3'b100, 8'd100}));
    check("full_pop_level", 32'(level), 32'd15);
    check("full_ready_again", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("full_17th_in", 32'(level), 32'd16);
    check("full_end_row", 32'(outs()), 32'({3'b010, 8'd100}));
    tick();
    check("full_end", 32'(outs()), 32'({3'b001, 8'd100}));

    // Drain all 16 with a 4x4 matrix; last element must be the 17th push
    cfg_valid = 1'b1;
    cfg_rows  = 8'd4;
    cfg_cols  = 8'd4;
    tick();
    cfg_valid = 1'b0;
    n_en = 0; n_row = 0; n_end = 0; last = '0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (out_matrix_en) begin n_en++; last = out_matrix; end
      if (out_matrix_end_row) n_row++;
      if (out_matrix_end) begin n_end++; break; end
    end
    check("drain_en", 32'(n_en), 32'd16);
    check("drain_rows", 32'(n_row), 32'd4);
    check("drain_end", 32'(n_end), 32'd1);
    check("drain_last", 32'(last), 32'd200);
    check("drain_level", 32'(level), 32'd0);

    // Starvation: 1x4 fed with gaps
    cfg_valid = 1'b1;
    cfg_rows  = 8'd1;
    cfg_cols  = 8'd4;
    tick();
    cfg_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_data  = 8'(10 * k);
      tick();
      in_valid = 1'b0;
      check($sformatf("starve_wait_%0d", k), 32'(out_matrix_en), 32'd0);
      tick();
      check($sformatf("starve_pop_%0d", k), 32'(outs()), 32'({3'b100, 8'(10 * k)}));
      if (k < 4) begin
        tick();
        check($sformatf("starve_gap_a_%0d", k), 32'(out_matrix_en), 32'd0);
        tick();
        check($sformatf("starve_gap_b_%0d", k), 32'(out_matrix_en), 32'd0);
      end
    end
    tick();
    check("starve_end_row", 32'(outs()), 32'({3'b010, 8'd40}));
    tick();
    check("starve_end", 32'(outs()), 32'({3'b001, 8'd40}));
    check("starve_busy", 32'(busy), 32'd0);

    // Illegal config
    cfg_valid = 1'b1;
    cfg_rows  = 8'd0;
    cfg_cols  = 8'd3;
    tick();
    check("zero_rows_busy", 32'(busy), 32'd0);
    cfg_rows = 8'd2;
    cfg_cols = 8'd2;
    tick();
    cfg_rows = 8'd5;
    cfg_cols = 8'd5;
    tick();
    cfg_valid = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    check("ign_no_out", 32'(out_matrix_en), 32'd0);
    n_en = 0; n_row = 0; n_end = 0; last = '0;
    for (int i = 0; i < 40; i++) begin
      in_valid = (i < 6);
      in_data  = 8'(i + 1);
      tick();
      if (out_matrix_en) begin n_en++; last = out_matrix; end
      if (out_matrix_end_row) n_row++;
      if (out_matrix_end) begin n_end++; break; end
    end
    in_valid = 1'b0;
    check("ign_en", 32'(n_en), 32'd4);
    check("ign_rows", 32'(n_row), 32'd2);
    check("ign_end", 32'(n_end), 32'd1);
    check("ign_last", 32'(last), 32'd4);
    check("ign_level", 32'(level), 32'd2);

    // Reset mid-matrix
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
    end
    in_valid  = 1'b0;
    cfg_valid = 1'b1;
    cfg_rows  = 8'd2;
    cfg_cols  = 8'd2;
    tick();
    cfg_valid = 1'b0;
    n_en = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_matrix_en) n_en++;
      if (n_en == 3) break;
    end
    check("mid_third_seen", 32'(n_en), 32'd3);
    check("mid_level_before", 32'(level), 32'd3);
    resetn = 1'b0;
    #1;
    check("mid_rst_outs", 32'(outs()), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    resetn = 1'b1;
    #1;
    check("mid_rel_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'd7;
    tick();
    in_valid  = 1'b0;
    cfg_valid = 1'b1;
    cfg_rows  = 8'd1;
    cfg_cols  = 8'd1;
    tick();
    cfg_valid = 1'b0;
    check("fresh_busy", 32'(busy), 32'd1);
    tick();
    check("fresh_en", 32'(outs()), 32'({3'b100, 8'd7}));
    tick();
    check("fresh_end_row", 32'(outs()), 32'({3'b010, 8'd7}));
    tick();
    check("fresh_end", 32'(outs()), 32'({3'b001, 8'd7}));
    check("fresh_busy_done", 32'(busy), 32'd0);
    check("fresh_level", 32'(level), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_stream_emitter.md
# matrix_stream_emitter

Buffers matrix elements written by the CPU-side store path and emits them on the system's `out_matrix` streaming port with row and matrix delimiters, so the simulation bench can print one row per line. It sits inside `system`, between the memory-mapped matrix-output write decode and the top-level ports `out_matrix_en`, `out_matrix`, `out_matrix_end_row` and `out_matrix_end`. Matrix dimensions are configured per matrix. Elements may be pre-loaded before configuration and are buffered in an internal FIFO.

## Interface
- `DATA_WIDTH`, default 8: element width.
- `DIM_WIDTH`, default 8: width of the row and column counts.
- `FIFO_DEPTH`, default 16: element FIFO depth. Must be a power of 2 and ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  one-cycle strobe that loads the dimensions.
- `cfg_rows`  in  DIM_WIDTH  number of rows.
- `cfg_cols`  in  DIM_WIDTH  number of columns.
- `in_valid`  in  1  element write strobe.
- `in_data`  in  DATA_WIDTH  element value.
- `in_ready`  out  1  FIFO can accept an element.
- `out_matrix_en`  out  1  `out_matrix` is valid this cycle.
- `out_matrix`  out  DATA_WIDTH  element value.
- `out_matrix_end_row`  out  1  one-cycle row-end pulse.
- `out_matrix_end`  out  1  one-cycle matrix-end pulse.
- `busy`  out  1  a matrix is in progress.
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- **FIFO**
  - A push occurs when `in_valid && in_ready`.
  - `in_ready = resetn && (level != FIFO_DEPTH)`, combinational.
  - When the FIFO is full, a push is refused even if a pop happens in the same cycle.
  - Pushes are accepted in every state, including IDLE (pre-load).
  - A simultaneous push and pop leaves `level` unchanged.
- **FSM states:** IDLE, EMIT, ROW_END, MAT_END.
  - **IDLE:** `cfg_valid` with `cfg_rows != 0` and `cfg_cols != 0`:
    - latch both dimensions;
    - clear the `row` and `col` counters;
    - go to EMIT.
    - A `cfg_valid` carrying a zero dimension is ignored.
  - **EMIT:** if `level != 0`:
    - pop one element and register `out_matrix_en=1` and `out_matrix` = the popped data;
    - if `col == cols-1`, clear `col` and go to ROW_END;
    - otherwise increment `col`.
    - If `level == 0`, wait with `out_matrix_en=0`.
  - **ROW_END:** register `out_matrix_end_row=1`.
    - If `row == rows-1`, go to MAT_END.
    - Otherwise increment `row` and return to EMIT.
  - **MAT_END:** register `out_matrix_end=1`, then go to IDLE.
- `cfg_valid` outside IDLE is ignored and the latched dimensions are unchanged.
- `busy = (state != IDLE)`, registered alongside the state.
- In each cycle at most one of `out_matrix_en`, `out_matrix_end_row`, `out_matrix_end` is high.
- `out_matrix` holds its last value when `out_matrix_en=0`.
- Counters are DIM_WIDTH bits and compare against the latched values. No wrap is possible because the dimensions are nonzero.

## Timing
- **Reset (async, `resetn` low):**
  - state = IDLE;
  - FIFO empty, `level=0`;
  - `out_matrix_en`, `out_matrix`, `out_matrix_end_row`, `out_matrix_end`, `busy` = 0;
  - `in_ready=0` while `resetn` is low.
- Reset asserted mid-matrix discards the FIFO contents and the counters immediately.
- **Config latency:** `cfg_valid` sampled at edge E gives `busy=1` from E.
- **Element latency:**
  - The first element pop can register at edge E+1 if `level != 0` at E+1.
  - A push sampled at edge E into an empty FIFO while in EMIT yields `out_matrix_en` high from edge E+1 to E+2.
- **Throughput:** one element per cycle within a row. Each row end costs one cycle. The matrix end costs one further cycle.
- A full R×C matrix with a pre-filled FIFO completes in R·C + R + 1 cycles from the first EMIT edge to IDLE.
- All outputs except `in_ready` are registered.

## Test plan
- **Reset:** hold `resetn=0` for 5 cycles, then release.
  - During reset: all outputs 0 and `in_ready=0`.
  - After release: `in_ready=1`, `level=0`, `busy=0`.
- **2×3 pre-loaded:** push 1..6 in IDLE (`level=6`), then `cfg_rows=2`, `cfg_cols=3`.
  - Required sequence: en 1,2,3, end_row, en 4,5,6, end_row, end.
  - The sequence takes 9 consecutive cycles, then `busy=0` and `level=0`.
- **Full FIFO:** push 17 elements in IDLE with `FIFO_DEPTH=16`.
  - `in_ready` drops after the 16th push and `level=16`.
  - The 17th element is not accepted until a pop occurs.
- **Starvation:** cfg 1×4, then feed 10,20,30,40 with 3-cycle gaps.
  - `out_matrix_en` pulses only one cycle after each push.
  - `end_row` follows 40 in the next cycle, then `end`.
- **Illegal config:**
  - `cfg_rows=0` in IDLE leaves `busy=0`.
  - `cfg_valid` with 5×5 during a 2×2 matrix is ignored: exactly 4 elements, 2 end_rows and 1 end are emitted.
- **Reset mid-matrix:** in a 2×2 matrix, assert `resetn=0` after the 3rd element.
  - Outputs go to 0 asynchronously and `level=0`.
  - After release, a fresh 1×1 matrix with value 7 emits en(7), end_row, end.
